// File: rtl/serial_tx_piso.sv
// Framed PISO serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity slot before the stop bit.
module serial_tx_piso #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_reg, state_next;
  logic [TICK_W-1:0]  tick_reg, tick_next;
  logic [BIT_W-1:0]   bit_reg, bit_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [WIDTH-1:0]   shift_dn;
  logic               sout_reg, sout_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               ready_reg, ready_next;
  logic               tick_wrap;
`ifdef SERIAL_TX_PARITY_EN
  logic               parity_reg, parity_next;
`endif

  assign shift_dn  = shift_reg >> 1;
  assign tick_wrap = (tick_reg == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!res) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      sout_reg   <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      ready_reg  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      sout_reg   <= sout_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      ready_reg  <= ready_next;
`ifdef SERIAL_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Outputs are computed as next-state values so every port is a flop.
  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    sout_next   = sout_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    ready_next  = ready_reg;
`ifdef SERIAL_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        sout_next  = 1'b1;
        busy_next  = 1'b0;
        ready_next = 1'b1;
        if (load_valid) begin
          state_next  = START;
          shift_next  = din;
          tick_next   = '0;
          bit_next    = '0;
          sout_next   = 1'b0;
          busy_next   = 1'b1;
          ready_next  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          parity_next = ^din;
`endif
        end
      end

      START: begin
        if (tick_wrap) begin
          state_next = DATA;
          tick_next  = '0;
          bit_next   = '0;
          sout_next  = shift_reg[0];
        end else begin
          tick_next  = tick_reg + TICK_W'(1);
        end
      end

      DATA: begin
        if (tick_wrap) begin
          tick_next = '0;
          if (bit_reg == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_next = PARITY;
            sout_next  = parity_reg;
`else
            state_next = STOP;
            sout_next  = 1'b1;
`endif
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = shift_dn;
            sout_next  = shift_dn[0];
          end
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tick_wrap) begin
          state_next = STOP;
          tick_next  = '0;
          sout_next  = 1'b1;
        end else begin
          tick_next  = tick_reg + TICK_W'(1);
        end
      end
`endif

      STOP: begin
        if (tick_wrap) begin
          // Landing in IDLE with ready set lets a word arrive in the done cycle.
          state_next = IDLE;
          tick_next  = '0;
          sout_next  = 1'b1;
          busy_next  = 1'b0;
          ready_next = 1'b1;
          done_next  = 1'b1;
        end else begin
          tick_next  = tick_reg + TICK_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        sout_next  = 1'b1;
        busy_next  = 1'b0;
        ready_next = 1'b1;
      end
    endcase
  end

  assign sout       = sout_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign load_ready = ready_reg;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Directed bench for serial_tx_piso (WIDTH=8, CLKS_PER_BIT=4); outputs sampled on negedge.
module tb_serial_tx_piso;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int SLOTS = WIDTH + 3;
`else
  localparam int SLOTS = WIDTH + 2;
`endif
  localparam int FRAME_CYC = SLOTS * CPB;

  logic             clk;
  logic             res;
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             busy;
  logic             done;

  int n_checks;
  int n_fail;
  int done_cnt;

  serial_tx_piso #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .res        (res),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Slot 0 is the start bit and the top slot the stop bit.
  function automatic logic [SLOTS-1:0] frame_pat(input logic [WIDTH-1:0] d);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Call at a negedge with din/load_valid already driven; the next posedge is E0.
  task automatic check_frame(input string name, input logic [SLOTS-1:0] pat, input bit keep_valid,
                             input logic [WIDTH-1:0] next_din, input int inject_k, input int abort_k);
    int slot;
    @(posedge clk);
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      if (abort_k >= 0 && k == abort_k) begin
        check_val({name, "_rst_sout"}, 32'(sout), 32'd1);
        check_val({name, "_rst_busy"}, 32'(busy), 32'd0);
        check_val({name, "_rst_ready"}, 32'(load_ready), 32'd1);
        check_val({name, "_rst_done"}, 32'(done), 32'd0);
        res = 1'b1;
        $display("frame %s din=%0h: reset at k=%0d", name, pat[WIDTH:1], k);
        return;
      end
      slot = k / CPB;
      check_val($sformatf("%s_sout_k%0d", name, k), 32'(sout), 32'(pat[slot]));
      check_val($sformatf("%s_busy_k%0d", name, k), 32'(busy), 32'd1);
      check_val($sformatf("%s_done_k%0d", name, k), 32'(done), 32'd0);
      check_val($sformatf("%s_ready_k%0d", name, k), 32'(load_ready), 32'd0);
      if (k == 0) begin
        din = next_din;
        if (!keep_valid) load_valid = 1'b0;
      end
      if (inject_k >= 0 && k == inject_k - 1) load_valid = 1'b1;
      if (inject_k >= 0 && k == inject_k) load_valid = 1'b0;
      if (abort_k >= 0 && k == abort_k - 1) res = 1'b0;
    end
    @(negedge clk);
    check_val({name, "_done"}, 32'(done), 32'd1);
    check_val({name, "_end_busy"}, 32'(busy), 32'd0);
    check_val({name, "_end_ready"}, 32'(load_ready), 32'd1);
    check_val({name, "_end_sout"}, 32'(sout), 32'd1);
    $display("frame %s din=%0h: %0d cycles, done seen", name, pat[WIDTH:1], FRAME_CYC);
  endtask

  initial begin
    int base;
    logic [9:0] a5_pat;
    n_checks   = 0;
    n_fail     = 0;
    done_cnt   = 0;
    res        = 1'b0;
    load_valid = 1'b1;
    din        = 8'hA5;

    // Reset held with load_valid high must not start a frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_sout", 32'(sout), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_ready", 32'(load_ready), 32'd1);
    end
    load_valid = 1'b0;
    res        = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    check_val("post_rst_sout", 32'(sout), 32'd1);
    $display("reset: idle outputs after 3 reset edges");

    // A5 LSB first: 0,1,0,1,0,0,1,0,1,1 (slot 0 in the LSB).
    a5_pat = 10'b1101001010;
    base = done_cnt;
    din = 8'hA5;
    load_valid = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
    check_frame("a5", frame_pat(8'hA5), 1'b0, 8'h5A, -1, -1);
`else
    check_frame("a5", a5_pat, 1'b0, 8'h5A, -1, -1);
`endif
    @(negedge clk);
    check_val("a5_done_once", 32'(done_cnt - base), 32'd1);
    check_val("a5_done_low", 32'(done), 32'd0);

    // Load attempt at k=10 must be ignored.
    din = 8'h3C;
    load_valid = 1'b1;
    check_frame("midload", frame_pat(8'h3C), 1'b0, 8'hFF, 10, -1);
    @(negedge clk);

    // Back-to-back with load_valid held high throughout.
    base = done_cnt;
    din = 8'h01;
    load_valid = 1'b1;
    check_frame("b2b_1", frame_pat(8'h01), 1'b1, 8'h80, -1, -1);
    check_frame("b2b_2", frame_pat(8'h80), 1'b0, 8'h00, -1, -1);
    @(negedge clk);
    check_val("b2b_done_count", 32'(done_cnt - base), 32'd2);

    // Reset at k=17, then confirm no done pulse and a clean next frame.
    base = done_cnt;
    din = 8'hC3;
    load_valid = 1'b1;
    check_frame("abort", frame_pat(8'hC3), 1'b0, 8'h00, -1, 17);
    repeat (50) @(negedge clk);
    check_val("abort_no_done", 32'(done_cnt - base), 32'd0);
    check_val("abort_idle_sout", 32'(sout), 32'd1);
    din = 8'h96;
    load_valid = 1'b1;
    check_frame("after_abort", frame_pat(8'h96), 1'b0, 8'h00, -1, -1);

`ifdef SERIAL_TX_PARITY_EN
    @(negedge clk);
    din = 8'h07;
    load_valid = 1'b1;
    check_frame("par07", {1'b1, 1'b1, 8'h07, 1'b0}, 1'b0, 8'h00, -1, -1);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
